// File: rtl/demux_dispatch_seq.sv
// demux_dispatch_seq: buffers (data, dest) items in a small FIFO and issues
// each head item as a one-cycle demuxIn/sel/enable strobe toward an 8-way
// demultiplexer once its destination lane is ready. A head that stays blocked
// for TIMEOUT cycles is discarded and counted, so the FIFO cannot deadlock.
module demux_dispatch_seq #(
  parameter int nrOfBits = 8,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [nrOfBits-1:0]       in_data,
  input  logic [2:0]                in_dest,
  output logic                      in_ready,
  input  logic [7:0]                lane_ready,
  output logic [nrOfBits-1:0]       demuxIn,
  output logic [2:0]                sel,
  output logic                      enable,
  output logic                      drop,
  output logic [7:0]                drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic          TO_EN    = (TIMEOUT != 0);
  // Last wait_cnt value before a drop; unused when dropping is disabled.
  localparam logic [15:0]   TO_LAST  = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  // FIFO storage and bookkeeping
  logic [nrOfBits-1:0] r_mem_data [DEPTH];
  logic [2:0]          r_mem_dest [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_level;

  // Dispatch state and registered outputs
  logic [15:0]         r_wait_cnt;
  logic                r_enable;
  logic                r_drop;
  logic [2:0]          r_sel;
  logic [nrOfBits-1:0] r_demux_in;
  logic [7:0]          r_drop_count;

  logic                w_empty;
  logic                w_push;
  logic                w_lane_ok;
  logic                w_issue;
  logic                w_drop;
  logic                w_pop;
  logic [2:0]          w_head_dest;
  logic [nrOfBits-1:0] w_head_data;

  // Head-of-queue decode: all decisions use the pre-edge head only.
  assign w_empty     = (r_level == {(AW+1){1'b0}});
  assign in_ready    = (r_level != LVL_FULL);
  assign w_push      = in_valid && in_ready;
  assign w_head_dest = r_mem_dest[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_lane_ok   = lane_ready[w_head_dest];
  assign w_issue     = !w_empty && w_lane_ok;
  assign w_drop      = !w_empty && !w_lane_ok && TO_EN && (r_wait_cnt == TO_LAST);
  assign w_pop       = w_issue || w_drop;

  // FIFO write side, pointers and occupancy; a full FIFO never accepts, even on a pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= {nrOfBits{1'b0}};
        r_mem_dest[i] <= 3'd0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= in_data;
        r_mem_dest[r_wr_ptr] <= in_dest;
        r_wr_ptr             <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Per-edge issue / drop / wait / idle decision and the registered demux strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= 1'b0;
      r_drop       <= 1'b0;
      r_sel        <= 3'd0;
      r_demux_in   <= {nrOfBits{1'b0}};
      r_drop_count <= 8'd0;
      r_wait_cnt   <= 16'd0;
    end else begin
      if (w_issue) begin
        r_enable   <= 1'b1;
        r_drop     <= 1'b0;
        r_sel      <= w_head_dest;
        r_demux_in <= w_head_data;
        r_wait_cnt <= 16'd0;
      end else if (w_drop) begin
        r_enable   <= 1'b0;
        r_drop     <= 1'b1;
        r_wait_cnt <= 16'd0;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end else begin
          r_drop_count <= r_drop_count;
        end
      end else if (!w_empty) begin
        r_enable   <= 1'b0;
        r_drop     <= 1'b0;
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end else begin
        r_enable   <= 1'b0;
        r_drop     <= 1'b0;
        r_wait_cnt <= 16'd0;
      end
    end
  end

  assign enable     = r_enable;
  assign drop       = r_drop;
  assign sel        = r_sel;
  assign demuxIn    = r_demux_in;
  assign drop_count = r_drop_count;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_demux_dispatch_seq.sv
// Bench for demux_dispatch_seq: a queue-based reference model predicts every
// registered output; scenario tasks drive random and directed traffic.
module tb_demux_dispatch_seq;

  localparam int NB      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_ready;
  logic [7:0] lane_ready;
  logic [7:0] demuxIn;
  logic [2:0] sel;
  logic       enable;
  logic       drop;
  logic [7:0] drop_count;
  logic [2:0] fifo_level;

  // second instance with dropping disabled
  logic       z_valid;
  logic [7:0] z_data;
  logic [2:0] z_dest;
  logic       z_ready;
  logic [7:0] z_lane;
  logic [7:0] z_din;
  logic [2:0] z_sel;
  logic       z_enable;
  logic       z_drop;
  logic [7:0] z_dc;
  logic [2:0] z_level;

  int errors = 0;
  int checks = 0;

  demux_dispatch_seq #(.nrOfBits(NB), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_ready(in_ready), .lane_ready(lane_ready),
    .demuxIn(demuxIn), .sel(sel), .enable(enable), .drop(drop),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  demux_dispatch_seq #(.nrOfBits(NB), .DEPTH(DEPTH), .TIMEOUT(0)) u_dut_nt (
    .clock(clock), .reset_n(reset_n), .in_valid(z_valid), .in_data(z_data),
    .in_dest(z_dest), .in_ready(z_ready), .lane_ready(z_lane),
    .demuxIn(z_din), .sel(z_sel), .enable(z_enable), .drop(z_drop),
    .drop_count(z_dc), .fifo_level(z_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] dest;
  } item_t;

  item_t      q[$];
  int         m_wait;
  int         m_dc;
  logic       m_en;
  logic       m_drop;
  logic [2:0] m_sel;
  logic [7:0] m_din;
  bit         m_acc;

  logic [24:0] obs_v;
  assign obs_v = {enable, sel, demuxIn, drop, drop_count, fifo_level, in_ready};

  localparam logic [24:0] RESET_VEC = {1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1};

  function automatic logic [24:0] expected_vec();
    logic [2:0] lvl;
    logic       rdy;
    lvl = 3'(q.size());
    rdy = (q.size() < DEPTH);
    return {m_en, m_sel, m_din, m_drop, 8'(m_dc), lvl, rdy};
  endfunction

  task automatic model_reset();
    q.delete();
    m_wait = 0;
    m_dc   = 0;
    m_en   = 1'b0;
    m_drop = 1'b0;
    m_sel  = 3'd0;
    m_din  = 8'h00;
    m_acc  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from the current inputs.
  task automatic model_step();
    item_t h;
    item_t it;
    bit    can_push;
    can_push = (q.size() < DEPTH);
    m_drop = 1'b0;
    m_acc  = 1'b0;
    if (q.size() == 0) begin
      m_en   = 1'b0;
      m_wait = 0;
    end else begin
      h = q[0];
      if (lane_ready[h.dest]) begin
        m_en  = 1'b1;
        m_sel = h.dest;
        m_din = h.data;
        q.delete(0);
        m_wait = 0;
      end else if (TIMEOUT != 0 && m_wait == TIMEOUT - 1) begin
        m_en   = 1'b0;
        m_drop = 1'b1;
        q.delete(0);
        m_wait = 0;
        if (m_dc < 255) m_dc++;
      end else begin
        m_en = 1'b0;
        m_wait++;
      end
    end
    if (in_valid && can_push) begin
      it.data = in_data;
      it.dest = in_dest;
      q.push_back(it);
      m_acc = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h3C;
    #1;
    checks++;
    if (obs_v !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state observed=%h expected=%h", obs_v, RESET_VEC);
    end
    @(posedge clock);
    #1;
    checks++;
    if (obs_v !== RESET_VEC || z_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold observed=%h expected=%h", obs_v, RESET_VEC);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    lane_ready = 8'hFF;
    in_valid = 1'b1;
    in_data = 8'hA5;
    in_dest = 3'd3;
    tick();
    checks++;
    if (obs_v !== expected_vec() || enable !== 1'b0) begin
      errors++;
      $display("FAIL single_accept observed=%h expected=%h", obs_v, expected_vec());
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({enable, sel, demuxIn} !== {1'b1, 3'd3, 8'hA5} || obs_v !== expected_vec()) begin
      errors++;
      $display("FAIL single_issue observed en=%b sel=%0d data=%h expected en=1 sel=3 data=a5",
               enable, sel, demuxIn);
    end
    tick();
    checks++;
    if (enable !== 1'b0 || obs_v !== expected_vec()) begin
      errors++;
      $display("FAIL single_one_cycle observed en=%b expected en=0", enable);
    end
  endtask

  task automatic test_back_to_back();
    int n_en = 0;
    int first = -1;
    int last = -1;
    int max_lvl = 0;
    int exp_sel = 0;
    lane_ready = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_data = 8'($urandom);
      in_dest = 3'(i);
      tick();
      checks++;
      if (obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL b2b_cycle%0d observed=%h expected=%h", i, obs_v, expected_vec());
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (enable === 1'b1) begin
        checks++;
        if (sel !== 3'(exp_sel)) begin
          errors++;
          $display("FAIL b2b_order observed sel=%0d expected sel=%0d", sel, exp_sel);
        end
        exp_sel++;
        n_en++;
        if (first < 0) first = i;
        last = i;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_en != 8 || last - first != 7 || max_lvl > 2) begin
      errors++;
      $display("FAIL b2b_stream observed enables=%0d span=%0d maxlvl=%0d expected 8/7/<=2",
               n_en, last - first, max_lvl);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] dests [5];
    logic [7:0] datas [5];
    int idx = 0;
    int got = 0;
    int guard = 0;
    bit saw_full = 0;
    for (int i = 0; i < 5; i++) begin
      dests[i] = 3'($urandom);
      datas[i] = 8'($urandom);
    end
    lane_ready = 8'h00;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 5);
      in_data = datas[idx % 5];
      in_dest = dests[idx % 5];
      tick();
      if (m_acc) idx++;
      checks++;
      if (obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL bp_fill%0d observed=%h expected=%h", c, obs_v, expected_vec());
      end
      if (idx == 4 && !saw_full) begin
        saw_full = 1;
        checks++;
        if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin
          errors++;
          $display("FAIL bp_full observed ready=%b lvl=%0d expected ready=0 lvl=4",
                   in_ready, fifo_level);
        end
      end
    end
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL bp_held observed accepted=%0d expected 4", idx);
    end
    lane_ready = 8'hFF;
    while ((got < 5) && (guard < 30)) begin
      in_valid = (idx < 5);
      in_data = datas[idx % 5];
      in_dest = dests[idx % 5];
      tick();
      guard++;
      if (m_acc) idx++;
      checks++;
      if (obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL bp_drain observed=%h expected=%h", obs_v, expected_vec());
      end
      if (enable === 1'b1) begin
        checks++;
        if (sel !== dests[got] || demuxIn !== datas[got]) begin
          errors++;
          $display("FAIL bp_order item%0d observed %0d/%h expected %0d/%h",
                   got, sel, demuxIn, dests[got], datas[got]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL bp_all_issued observed=%0d expected=5", got);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    lane_ready = 8'hFF;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    lane_ready = 8'hDF;
    in_valid = 1'b1;
    in_data = 8'h55;
    in_dest = 3'd5;
    tick();
    in_data = 8'h66;
    in_dest = 3'd2;
    while (drop !== 1'b1 && n < 40) begin
      tick();
      in_valid = 1'b0;
      n++;
      checks++;
      if (obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL to_wait%0d observed=%h expected=%h", n, obs_v, expected_vec());
      end
    end
    checks++;
    if (n != 16 || drop_count !== 8'd1 || enable !== 1'b0) begin
      errors++;
      $display("FAIL to_drop observed edges=%0d count=%0d expected edges=16 count=1",
               n, drop_count);
    end
    tick();
    checks++;
    if ({enable, sel, demuxIn, drop} !== {1'b1, 3'd2, 8'h66, 1'b0}) begin
      errors++;
      $display("FAIL to_next_issue observed en=%b sel=%0d data=%h drop=%b expected 1/2/66/0",
               enable, sel, demuxIn, drop);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      in_dest = 3'($urandom);
      lane_ready = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      tick();
      checks++;
      if (obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL rand_cycle%0d observed=%h expected=%h", i, obs_v, expected_vec());
      end
    end
    in_valid = 1'b0;
    lane_ready = 8'hFF;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_mid();
    lane_ready = 8'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      in_dest = 3'($urandom);
      tick();
    end
    in_valid = 1'b0;
    lane_ready = 8'hFF;
    tick();
    checks++;
    if (enable !== 1'b1 || fifo_level !== 3'd3 || obs_v !== expected_vec()) begin
      errors++;
      $display("FAIL mid_setup observed en=%b lvl=%0d expected en=1 lvl=3", enable, fifo_level);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_v !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset observed=%h expected=%h", obs_v, RESET_VEC);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (enable !== 1'b0 || obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL mid_stale%0d observed=%h expected=%h", i, obs_v, expected_vec());
      end
    end
  endtask

  task automatic test_saturate();
    int drops = 0;
    int guard = 0;
    lane_ready = 8'h00;
    in_valid = 1'b1;
    while (drops < 260 && guard < 6000) begin
      in_data = 8'($urandom);
      in_dest = 3'($urandom);
      tick();
      guard++;
      if (drop === 1'b1) drops++;
      checks++;
      if (obs_v !== expected_vec()) begin
        errors++;
        $display("FAIL sat_cycle%0d observed=%h expected=%h", guard, obs_v, expected_vec());
      end
    end
    checks++;
    if (drops != 260 || drop_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_count observed drops=%0d count=%0d expected drops=260 count=255",
               drops, drop_count);
    end
    in_valid = 1'b0;
    lane_ready = 8'hFF;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_no_timeout();
    z_lane = 8'h00;
    z_valid = 1'b1;
    z_data = 8'h5A;
    z_dest = 3'd4;
    tick();
    z_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({z_drop, z_enable, z_level, z_dc} !== {1'b0, 1'b0, 3'd1, 8'd0}) begin
        errors++;
        $display("FAIL nt_wait%0d observed drop=%b en=%b lvl=%0d count=%0d expected 0/0/1/0",
                 i, z_drop, z_enable, z_level, z_dc);
      end
    end
    z_lane = 8'h10;
    tick();
    checks++;
    if ({z_enable, z_sel, z_din, z_level} !== {1'b1, 3'd4, 8'h5A, 3'd0}) begin
      errors++;
      $display("FAIL nt_issue observed en=%b sel=%0d data=%h lvl=%0d expected 1/4/5a/0",
               z_enable, z_sel, z_din, z_level);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_dest = 3'd0;
    lane_ready = 8'hFF;
    z_valid = 1'b0;
    z_data = 8'h00;
    z_dest = 3'd0;
    z_lane = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_mid();
    test_saturate();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
